// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder
//   Memory-side responder for the PicoRV32 native memory interface. Serves
//   instruction fetches, loads and byte-masked stores from an internal word
//   array. Each completion is held off by WAIT_STATES cycles. The block also
//   counts completed instruction fetches, and that count saturates.
//
// Optional feature: define MEM_RESP_BUS_ERR_EN to range-check accesses.
//   Out-of-range accesses then return 0, do not write the array, and raise
//   bus_err with mem_ready. When the macro is undefined, the index wraps
//   modulo MEM_WORDS and bus_err is always 0.
//
// Ports
//   clk          clock, rising edge
//   resetn       async active-low reset
//   mem_valid    request valid
//   mem_instr    request is an instruction fetch
//   mem_addr     byte address (bits [1:0] ignored)
//   mem_wdata    store data
//   mem_wstrb    byte enables, 4'b0000 = read
//   mem_ready    one-cycle completion strobe (registered)
//   mem_rdata    read data while mem_ready=1, else 0 (registered)
//   bus_err      error strobe alongside mem_ready (registered)
//   fetch_count  completed instruction fetches, saturating
module picorv32_mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } req_t;

  state_t      state;
  req_t        cap;
  req_t        req;
  logic [7:0]  cnt;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        err;
  logic        enter_resp;
  logic        wr_en;
  logic        unused_off;

  // Array is not reset. It powers up filled with INIT_WORD.
  logic [31:0] mem [MEM_WORDS] = '{default: INIT_WORD};

  // In IDLE, the live bus is the request. This is what lets WAIT_STATES=0
  // capture and complete on the same edge. In WAIT, only the captured copy
  // counts, so bus changes after capture are ignored.
  always_comb begin
    req = cap;
    if (state == IDLE) begin
      req.addr  = mem_addr;
      req.wdata = mem_wdata;
      req.wstrb = mem_wstrb;
      req.instr = mem_instr;
    end
  end

  assign off        = req.addr - BASE_ADDR;
  assign idx        = off[AW+1:2];
  assign unused_off = ^off;

`ifdef MEM_RESP_BUS_ERR_EN
  assign err = (req.addr < BASE_ADDR) || ((off >> 2) >= 32'(MEM_WORDS));
`else
  assign err = 1'b0;
`endif

  // The response is produced on the edge that moves into RESP.
  assign enter_resp = mem_valid &&
                      ((state == IDLE && WAIT_STATES == 0) ||
                       (state == WAIT && cnt == 8'd1));

  assign wr_en = resetn && enter_resp && (|req.wstrb) && !err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (req.wstrb[b]) mem[idx][8*b +: 8] <= req.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cap         <= '0;
      cnt         <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      bus_err     <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Strobe outputs fall back to 0 unless this edge completes a request.
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: if (mem_valid) begin
          cap   <= req;
          cnt   <= 8'(WAIT_STATES);
          state <= (WAIT_STATES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          // Losing mem_valid mid-wait is a protocol violation. Drop the request.
          if (!mem_valid)          state <= IDLE;
          else begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1)       state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        mem_ready <= 1'b1;
        mem_rdata <= ((|req.wstrb) || err) ? 32'h0 : mem[idx];
        bus_err   <= err;
        if (req.instr && fetch_count != 32'hFFFF_FFFF)
          fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
